// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared constants, FSM state type and id-width helper for add_arbiter
package add_arb_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/add_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, lowest requester at or above ptr, wrapping to the lowest below it
//   req     : request vector
//   ptr     : priority start index
//   gnt     : one-hot winner (zero when nothing requests)
//   gnt_idx : binary index of the winner
//   any     : at least one request present
module rr_pick
  import add_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);
  logic           w_hit_hi;
  logic [IDW-1:0] w_idx_hi;
  logic [IDW-1:0] w_idx_lo;
  // Descending scan so the lowest matching index is written last and wins.
  always_comb begin
    w_hit_hi = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IDW'(i) >= ptr)) begin
        w_hit_hi = 1'b1;
        w_idx_hi = IDW'(i);
      end
      if (req[i]) w_idx_lo = IDW'(i);
    end
    gnt_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
  end
  assign any = |req;
  assign gnt = any ? (N'(1) << gnt_idx) : '0;
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sequencer sharing one 32-bit adder among N requesters
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_a/req_b : per-requester operand requests (32 bits per slot)
//   req_ready             : one-hot combinational accept
//   adder_a/adder_b       : registered operands to the shared adder
//   adder_sum             : adder result, valid ADD_LAT cycles after operands settle
//   resp_valid/resp_id/resp_sum/resp_ready : response channel
//   busy                  : FSM not idle
// Optional macro ADD_ARB_CARRY_EN adds req_cin, adder_cin, adder_cout, resp_cout.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*DATA_W-1:0]  req_a,
  input  logic [N*DATA_W-1:0]  req_b,
  output logic [N-1:0]         req_ready,
  output logic [DATA_W-1:0]    adder_a,
  output logic [DATA_W-1:0]    adder_b,
  input  logic [DATA_W-1:0]    adder_sum,
  output logic                 resp_valid,
  output logic [idw(N)-1:0]    resp_id,
  output logic [DATA_W-1:0]    resp_sum,
  input  logic                 resp_ready,
  output logic                 busy
`ifdef ADD_ARB_CARRY_EN
  ,
  input  logic [N-1:0]         req_cin,
  output logic                 adder_cin,
  input  logic                 adder_cout,
  output logic                 resp_cout
`endif
);
  localparam int IDW = idw(N);
  localparam int CW  = $clog2(ADD_LAT + 1);
  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_sum;
  logic                r_vld;
  logic [N-1:0]        w_gnt;
  logic [IDW-1:0]      w_gidx;
  logic                w_any;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic                w_acc;
  logic                w_done;
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx),
    .any     (w_any)
  );
  assign w_acc  = (r_state == IDLE) && w_any;
  assign w_done = (r_state == WAIT) && (r_cnt == CW'(1));
  // One-hot operand select driven by the grant.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N; i++) begin
      w_a |= w_gnt[i] ? req_a[i*DATA_W +: DATA_W] : '0;
      w_b |= w_gnt[i] ? req_b[i*DATA_W +: DATA_W] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = w_acc ? WAIT :
             w_done ? RESP :
             ((r_state == RESP) && resp_ready) ? IDLE : r_state;
  end
  // req_ready is gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    req_ready = (rst_n && (r_state == IDLE)) ? w_gnt : '0;
    busy      = (r_state != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_id  <= '0;
      r_sum <= '0;
      r_vld <= 1'b0;
    end else begin
      if (w_acc) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_id  <= w_gidx;
        r_ptr <= (w_gidx == IDW'(N - 1)) ? '0 : w_gidx + 1'b1;
        r_cnt <= CW'(ADD_LAT);
      end
      if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_done) begin
        r_sum <= adder_sum;
        r_vld <= 1'b1;
      end
      if ((r_state == RESP) && resp_ready) r_vld <= 1'b0;
    end
  end
  assign adder_a    = r_a;
  assign adder_b    = r_b;
  assign resp_valid = r_vld;
  assign resp_id    = r_id;
  assign resp_sum   = r_sum;
`ifdef ADD_ARB_CARRY_EN
  logic r_cin;
  logic r_cout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cin  <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      if (w_acc)  r_cin  <= |(w_gnt & req_cin);
      if (w_done) r_cout <= adder_cout;
    end
  end
  assign adder_cin = r_cin;
  assign resp_cout = r_cout;
`endif
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter (N=4, ADD_LAT=2)
module tb_add_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  adder_a;
  logic [31:0]  adder_b;
  logic [31:0]  adder_sum;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sum;
  logic         resp_ready;
  logic         busy;
  logic         cout_q;
  logic         cin_m;
  int           n_chk = 0;
  int           n_err = 0;
`ifdef ADD_ARB_CARRY_EN
  logic [3:0]   req_cin;
  logic         adder_cin;
  logic         resp_cout;
  assign cin_m = adder_cin;
`else
  assign cin_m = 1'b0;
`endif
  add_arbiter #(.N(4), .ADD_LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_sum  (adder_sum),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_ready (resp_ready),
    .busy       (busy)
`ifdef ADD_ARB_CARRY_EN
    ,
    .req_cin    (req_cin),
    .adder_cin  (adder_cin),
    .adder_cout (cout_q),
    .resp_cout  (resp_cout)
`endif
  );
  always #5 clk = ~clk;
  // Adder model: result appears one register stage (ADD_LAT-1) after the operands.
  always_ff @(posedge clk) {cout_q, adder_sum} <= {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, cin_m};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Called just after a negedge with the DUT idle; returns just after a negedge with the DUT idle.
  task automatic run_op(input logic [3:0] vld, input int g, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] exp_sum, input logic exp_cout, input int bp);
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    req_a[g*32 +: 32] = a;
    req_b[g*32 +: 32] = b;
`ifdef ADD_ARB_CARRY_EN
    req_cin    = '0;
    req_cin[g] = cin;
`endif
    req_valid  = vld;
    resp_ready = (bp == 0);
    #1 chk("grant", 64'(req_ready), 64'(4'b0001 << g));
    @(posedge clk);
    @(negedge clk);
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_rdy", 64'(req_ready), 64'd0);
    chk("adder_a", 64'(adder_a), 64'(a));
    chk("adder_b", 64'(adder_b), 64'(b));
    @(posedge clk);
    @(negedge clk);
    chk("early_valid", 64'(resp_valid), 64'd0);
    chk("hold_a", 64'(adder_a), 64'(a));
    @(posedge clk);
    @(negedge clk);
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("resp_id", 64'(resp_id), 64'(g));
    chk("resp_sum", 64'(resp_sum), 64'(exp_sum));
    chk("resp_rdy", 64'(req_ready), 64'd0);
`ifdef ADD_ARB_CARRY_EN
    chk("resp_cout", 64'(resp_cout), 64'(exp_cout));
`endif
    for (int k = 0; k < bp; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_sum", 64'(resp_sum), 64'(exp_sum));
      chk("bp_id", 64'(resp_id), 64'(g));
      chk("bp_rdy", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("done_valid", 64'(resp_valid), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
  endtask
  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_a      = {$urandom, $urandom, $urandom, $urandom};
    req_b      = {$urandom, $urandom, $urandom, $urandom};
    resp_ready = 1'b0;
`ifdef ADD_ARB_CARRY_EN
    req_cin    = 4'b1111;
`endif
    #12;
    chk("rst_rdy", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_a", 64'(adder_a), 64'd0);
    chk("rst_b", 64'(adder_b), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    chk("rst_sum", 64'(resp_sum), 64'd0);
`ifdef ADD_ARB_CARRY_EN
    chk("rst_cout", 64'(resp_cout), 64'd0);
    chk("rst_cin", 64'(adder_cin), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    // ptr=0 after reset: lowest valid index wins
    run_op(4'b0110, 1, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 0);
    run_op(4'b0100, 2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 0);
    run_op(4'b1000, 3, 32'h1234_0000, 32'h0000_5678, 1'b0, 32'h1234_5678, 1'b0, 0);
    // ptr=0: all requesting -> 0,1,2,3,0,1
    run_op(4'b1111, 0, 32'h0000_0100, 32'h0000_0005, 1'b0, 32'h0000_0105, 1'b0, 0);
    run_op(4'b1111, 1, 32'h0000_0200, 32'h0000_0005, 1'b0, 32'h0000_0205, 1'b0, 0);
    run_op(4'b1111, 2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 0);
    run_op(4'b1111, 3, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
    run_op(4'b1111, 0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 0);
    run_op(4'b1111, 1, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 0);
    // ptr=2: backpressure for 5 cycles
    run_op(4'b1111, 2, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 5);
    // ptr=3: only port 0 valid -> wraps to 0; reset during WAIT
    req_valid = 4'b0001;
    req_a[31:0] = 32'h0000_0011;
    req_b[31:0] = 32'h0000_0022;
    #1 chk("mid_grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_a", 64'(adder_a), 64'd0);
    chk("mid_b", 64'(adder_b), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_valid", 64'(resp_valid), 64'd0);
    chk("mid_sum", 64'(resp_sum), 64'd0);
    chk("mid_rdy", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // ptr back to 0: ports 1 and 3 valid -> 1 first
    run_op(4'b1010, 1, 32'h0000_00AA, 32'h0000_0055, 1'b0, 32'h0000_00FF, 1'b0, 0);
    run_op(4'b0001, 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0);
`ifdef ADD_ARB_CARRY_EN
    run_op(4'b0010, 1, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0, 0);
`else
    run_op(4'b0010, 1, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
